// File: rtl/expr_eval.sv
// Streaming evaluator for digit ((+|*) digit)* expressions: tracks the running
// value of the prefix consumed so far, plus validity, sticky syntax error and sticky overflow.
module expr_eval #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [7:0]   in,
  input  logic         in_valid,
  output logic [W-1:0] value,
  output logic         ok,
  output logic         err,
  output logic         ovf,
  output logic [1:0]   dbg_state_o
);

  // Input strobe: `in` is consumed on any posedge where in_valid=1; there is no
  // ready, the block accepts one character per cycle unconditionally.
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_NUM   = 2'd1,
    ST_OP    = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] term_q, term_d;
  logic         mul_pend_q, mul_pend_d;
  logic [W-1:0] value_q, value_d;
  logic         ok_q, ok_d;
  logic         err_q, err_d;
  logic         ovf_q, ovf_d;

  logic         is_dig, is_add, is_mul;
  logic [3:0]   dig;
  logic [W+3:0] prod;
  logic [W:0]   fold;
  logic [W:0]   total;

  assign is_dig = (in >= 8'd48) && (in <= 8'd57);
  assign is_add = (in == 8'd43);
  assign is_mul = (in == 8'd42);
  assign dig    = in[3:0];
  assign prod   = {4'b0000, term_q} * {{W{1'b0}}, dig};
  assign fold   = {1'b0, sum_q} + {1'b0, term_q};
  assign total  = {1'b0, sum_d} + {1'b0, term_d};

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    term_d     = term_q;
    mul_pend_d = mul_pend_q;
    value_d    = value_q;
    ok_d       = ok_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    if (in_valid) begin
      case (state_q)
        ST_START: begin
          if (is_dig) begin
            sum_d   = '0;
            term_d  = {{(W-4){1'b0}}, dig};
            state_d = ST_NUM;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_NUM: begin
          if (is_add) begin
            // The finished term moves into sum, so the open term restarts at zero.
            sum_d      = fold[W-1:0];
            term_d     = '0;
            mul_pend_d = 1'b0;
            ovf_d      = ovf_q | fold[W];
            state_d    = ST_OP;
          end else if (is_mul) begin
            mul_pend_d = 1'b1;
            state_d    = ST_OP;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_OP: begin
          if (is_dig) begin
            if (mul_pend_q) begin
              term_d = prod[W-1:0];
              ovf_d  = ovf_q | (|prod[W+3:W]);
            end else begin
              term_d = {{(W-4){1'b0}}, dig};
            end
            state_d = ST_NUM;
          end else begin
            state_d = ST_ERR;
          end
        end
        default: state_d = ST_ERR;
      endcase

      if (state_d == ST_ERR) begin
        // Syntax error wins: no overflow from the offending character.
        value_d = '0;
        ok_d    = 1'b0;
        err_d   = 1'b1;
        ovf_d   = ovf_q;
      end else begin
        value_d = total[W-1:0];
        ovf_d   = ovf_d | total[W];
        ok_d    = (state_d == ST_NUM);
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_START;
      sum_q      <= '0;
      term_q     <= '0;
      mul_pend_q <= 1'b0;
      value_q    <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      term_q     <= term_d;
      mul_pend_q <= mul_pend_d;
      value_q    <= value_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign value       = value_q;
  assign ok          = ok_q;
  assign err         = err_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: W=16 and W=8 instances share one character stream and are
// compared against a model that re-parses the whole accepted string each step.
module tb_expr_eval;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in_ch;

  logic [15:0] val16;
  logic        ok16, err16, ovf16;
  logic [1:0]  st16;
  logic [7:0]  val8;
  logic        ok8, err8, ovf8;
  logic [1:0]  st8;

  expr_eval #(.W(16)) dut16 (
    .clk(clk), .clr(clr), .in(in_ch), .in_valid(in_valid),
    .value(val16), .ok(ok16), .err(err16), .ovf(ovf16), .dbg_state_o(st16)
  );

  expr_eval #(.W(8)) dut8 (
    .clk(clk), .clr(clr), .in(in_ch), .in_valid(in_valid),
    .value(val8), .ok(ok8), .err(err8), .ovf(ovf8), .dbg_state_o(st8)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: accepted characters, sticky error, per-width overflow
  byte unsigned hist[$];
  bit           m_err;
  bit           m_ovf16;
  bit           m_ovf8;

  localparam longint unsigned CAP  = 64'h4_0000_0000;
  localparam longint unsigned M32  = 64'hFFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned sat(input longint unsigned x);
    return (x > CAP) ? CAP : x;
  endfunction

  // Evaluate the first n characters (n odd, ending in a digit): value mod 2^32
  // and the exact value saturated at CAP.
  function automatic void eval_prefix(input int n, output longint unsigned vmod,
                                      output longint unsigned vsat);
    longint unsigned s_m = 0, t_m = 0, s_s = 0, t_s = 0, d;
    for (int i = 0; i < n; i += 2) begin
      d = longint'(hist[i]) - 48;
      if (i == 0) begin
        t_m = d; t_s = d;
      end else if (hist[i-1] == 8'd43) begin
        s_m = (s_m + t_m) & M32; s_s = sat(s_s + t_s);
        t_m = d; t_s = d;
      end else begin
        t_m = (t_m * d) & M32; t_s = sat(t_s * d);
      end
    end
    vmod = (s_m + t_m) & M32;
    vsat = sat(s_s + t_s);
  endfunction

  function automatic logic [31:0] exp_value(input int w);
    longint unsigned vm, vs;
    int n;
    if (m_err || hist.size() == 0) return 32'd0;
    n = (hist.size() % 2 == 1) ? hist.size() : hist.size() - 1;
    eval_prefix(n, vm, vs);
    return 32'(vm & ((64'd1 << w) - 1));
  endfunction

  function automatic bit exp_ok();
    return !m_err && (hist.size() % 2 == 1);
  endfunction

  task automatic model_reset();
    hist.delete();
    m_err   = 1'b0;
    m_ovf16 = 1'b0;
    m_ovf8  = 1'b0;
  endtask

  task automatic model_step(input byte unsigned c);
    bit want_dig, is_dig, bad;
    longint unsigned vm, vs;
    if (m_err) return;
    want_dig = (hist.size() % 2 == 0);
    is_dig   = (c >= 48) && (c <= 57);
    bad      = want_dig ? !is_dig : !(c == 43 || c == 42);
    if (bad) begin
      m_err = 1'b1;
      return;
    end
    hist.push_back(c);
    if (is_dig) begin
      eval_prefix(hist.size(), vm, vs);
      if (vs >= (64'd1 << 16)) m_ovf16 = 1'b1;
      if (vs >= (64'd1 << 8))  m_ovf8  = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/val16"}, 32'(val16), exp_value(16));
    check({tag, "/ok16"},  32'(ok16),  32'(exp_ok()));
    check({tag, "/err16"}, 32'(err16), 32'(m_err));
    check({tag, "/ovf16"}, 32'(ovf16), 32'(m_ovf16));
    check({tag, "/val8"},  32'(val8),  exp_value(8));
    check({tag, "/ok8"},   32'(ok8),   32'(exp_ok()));
    check({tag, "/err8"},  32'(err8),  32'(m_err));
    check({tag, "/ovf8"},  32'(ovf8),  32'(m_ovf8));
  endtask

  // driver tasks: each starts and ends on a negedge
  task automatic send(input byte unsigned c);
    in_ch    = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    model_step(c);
    check_all($sformatf("char_%0d", c));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_ch = 8'($urandom_range(0, 255));
      @(negedge clk);
      check_all("idle");
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(negedge clk);
    model_reset();
    check_all("clr");
    clr = 1'b0;
  endtask

  initial begin
    byte unsigned c;
    int len, r;
    clr = 1'b1;
    in_valid = 1'b0;
    in_ch = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    clr = 1'b0;

    send_str("3+4*5");
    check("tp1_final", 32'(val16), 32'd23);

    do_reset();
    send_str("2*3*4+");
    check("tp2_plus_val", 32'(val16), 32'd24);
    check("tp2_plus_ok", 32'(ok16), 32'd0);
    send_str("1");
    check("tp2_final", 32'(val16), 32'd25);

    do_reset();
    send_str("12+3");
    check("tp3_err", 32'(err16), 32'd1);
    check("tp3_val", 32'(val16), 32'd0);
    do_reset();
    send_str("7");
    check("tp3_after_clr", 32'(val16), 32'd7);

    do_reset();
    send_str("9*9*9");
    check("tp4_val8", 32'(val8), 32'd217);
    check("tp4_ovf8", 32'(ovf8), 32'd1);
    check("tp4_val16", 32'(val16), 32'd729);
    send_str("+0");
    check("tp4_hold8", 32'(val8), 32'd217);
    check("tp4_ovf8_sticky", 32'(ovf8), 32'd1);

    do_reset(); send_str("+"); check("lead_add", 32'(err16), 32'd1);
    do_reset(); send_str("*"); check("lead_mul", 32'(err16), 32'd1);
    do_reset(); send_str("a"); check("lead_bad", 32'(err16), 32'd1);
    do_reset(); send_str("5+*"); check("op_op", 32'(err16), 32'd1);
    do_reset(); send_str("/"); check("below_0", 32'(err16), 32'd1);
    do_reset(); send_str(":"); check("above_9", 32'(err16), 32'd1);

    do_reset();
    send_str("4"); idle(3); send_str("*"); idle(3); send_str("6");
    check("gap_final", 32'(val16), 32'd24);

    do_reset();
    send_str("8*");
    #2 clr = 1'b1;
    #1;
    model_reset();
    check("async_val", 32'(val16), 32'd0);
    check_all("async");
    @(negedge clk);
    clr = 1'b0;
    send_str("3");
    check("async_after", 32'(val16), 32'd3);

    for (int it = 0; it < 60; it++) begin
      do_reset();
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 99);
        if (r < 4) c = (r < 2) ? 8'd47 : 8'd97;
        else if (r < 10 || (hist.size() % 2 == 0)) c = 8'($urandom_range(48, 57));
        else c = ($urandom_range(0, 1) == 1) ? 8'd43 : 8'd42;
        if (r < 10 && hist.size() % 2 == 0 && r >= 4) c = 8'($urandom_range(42, 43));
        send(c);
        if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
